// File: rtl/inst_queue.sv
// inst_queue: circular fetch->ROB instruction FIFO with head decode; IQ_PERF_EN adds stall counters.
// Latency: an entry is dispatchable the cycle after it is written (1-cycle minimum), one dispatch per cycle.
// Backpressure: fetch_ready = ~full with no pass-through; dispatch waits for rob_free & rs_ready.
module inst_queue #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   input  logic [31:0] fetch_instr,
   input  logic [31:0] fetch_pc,
   input  logic [31:0] fetch_predict,
   input  logic [2:0]  fetch_pc_save,
   input  logic        rob_free,
   input  logic        rs_ready,
   output logic        load_instruction,
   output logic [4:0]  reg_num_o,
   output logic [6:0]  opcode_o,
   output logic [31:0] imm_data,
   output logic [2:0]  pc_save_o,
   output logic [31:0] target_predict_o,
   output logic [31:0] instruction_o,
   output logic [31:0] inst_pc_o,
   output logic [31:0] b_imm_o,
   output logic [31:0] j_imm_o,
   output logic        empty
`ifdef IQ_PERF_EN
   ,
   output logic [31:0] full_stall_cnt,
   output logic [31:0] rob_stall_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] predict;
      logic [2:0]  pc_save;
   } iq_entry_t;

   iq_entry_t        entries_q [DEPTH];
   iq_entry_t        head_entry;
   iq_entry_t        wr_entry;

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             full;
   logic             is_empty;
   logic             push;
   logic             pop;

   logic [31:0]      head_instr;
   logic [6:0]       head_op;
   logic [31:0]      u_imm;

   // Full gates fetch regardless of a same-cycle pop, so there is never a pass-through path.
   always_comb begin
      full     = (count_q == CNT_W'(DEPTH));
      is_empty = (count_q == '0);
      push     = fetch_valid & ~full & ~flush;
      pop      = ~is_empty & rob_free & rs_ready & ~flush;
   end

   assign fetch_ready      = ~full;
   assign empty            = is_empty;
   assign load_instruction = pop;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + PTR_W'(1);
         if (pop)  head_d = head_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is deliberately not reset or cleared; only the pointers define validity.
   always_comb begin
      wr_entry.instr   = fetch_instr;
      wr_entry.pc      = fetch_pc;
      wr_entry.predict = fetch_predict;
      wr_entry.pc_save = fetch_pc_save;
   end

   always_ff @(posedge clk) begin
      if (push) entries_q[tail_q] <= wr_entry;
   end

   assign head_entry = entries_q[head_q];

   always_comb begin
      head_instr       = head_entry.instr;
      head_op          = head_instr[6:0];
      u_imm            = {head_instr[31:12], 12'b0};

      opcode_o         = head_op;
      instruction_o    = head_instr;
      inst_pc_o        = head_entry.pc;
      target_predict_o = head_entry.predict;
      pc_save_o        = head_entry.pc_save;

      reg_num_o = head_instr[11:7];
      if (head_op == OP_BR || head_op == OP_STORE) reg_num_o = '0;

      imm_data = '0;
      if (head_op == OP_LUI)        imm_data = u_imm;
      else if (head_op == OP_AUIPC) imm_data = head_entry.pc + u_imm;

      b_imm_o = {{20{head_instr[31]}}, head_instr[7], head_instr[30:25], head_instr[11:8], 1'b0};
      j_imm_o = {{12{head_instr[31]}}, head_instr[19:12], head_instr[20], head_instr[30:21], 1'b0};
   end

`ifdef IQ_PERF_EN
   logic [31:0] full_stall_q, full_stall_d;
   logic [31:0] rob_stall_q, rob_stall_d;

   // Saturating counters; they survive a flush so stall statistics span mispredicts.
   always_comb begin
      full_stall_d = full_stall_q;
      rob_stall_d  = rob_stall_q;
      if (fetch_valid && full && full_stall_q != 32'hFFFF_FFFF)
         full_stall_d = full_stall_q + 32'd1;
      if (!is_empty && !(rob_free && rs_ready) && rob_stall_q != 32'hFFFF_FFFF)
         rob_stall_d = rob_stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_stall_q <= '0;
         rob_stall_q  <= '0;
      end else begin
         full_stall_q <= full_stall_d;
         rob_stall_q  <= rob_stall_d;
      end
   end

   assign full_stall_cnt = full_stall_q;
   assign rob_stall_cnt  = rob_stall_q;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: driver queues expected entries, negedge monitor checks head decode and flags.
// Expected decode is computed arithmetically from the RV32I field definitions.
module tb_inst_queue;
   localparam int DEPTH = 8;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_predict;
   logic [2:0]  fetch_pc_save;
   logic        rob_free;
   logic        rs_ready;
   logic        load_instruction;
   logic [4:0]  reg_num_o;
   logic [6:0]  opcode_o;
   logic [31:0] imm_data;
   logic [2:0]  pc_save_o;
   logic [31:0] target_predict_o;
   logic [31:0] instruction_o;
   logic [31:0] inst_pc_o;
   logic [31:0] b_imm_o;
   logic [31:0] j_imm_o;
   logic        empty;
`ifdef IQ_PERF_EN
   logic [31:0] full_stall_cnt;
   logic [31:0] rob_stall_cnt;
   logic [31:0] m_full_cnt = 0;
   logic [31:0] m_rob_cnt  = 0;
`endif

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
      .fetch_predict(fetch_predict), .fetch_pc_save(fetch_pc_save),
      .rob_free(rob_free), .rs_ready(rs_ready),
      .load_instruction(load_instruction), .reg_num_o(reg_num_o),
      .opcode_o(opcode_o), .imm_data(imm_data), .pc_save_o(pc_save_o),
      .target_predict_o(target_predict_o), .instruction_o(instruction_o),
      .inst_pc_o(inst_pc_o), .b_imm_o(b_imm_o), .j_imm_o(j_imm_o),
      .empty(empty)
`ifdef IQ_PERF_EN
      , .full_stall_cnt(full_stall_cnt), .rob_stall_cnt(rob_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pred;
      logic [2:0]  tag;
   } item_t;

   item_t exp_q[$];
   item_t pend_item;
   bit    pend = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   bit    m_load;
   item_t m_h;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_bimm(input logic [31:0] i);
      int v;
      v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      return 32'(v);
   endfunction

   function automatic logic [31:0] exp_jimm(input logic [31:0] i);
      int v;
      v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      return 32'(v);
   endfunction

   function automatic logic [31:0] exp_imm(input logic [31:0] i, input logic [31:0] pc);
      logic [31:0] upper;
      upper = 32'(i[31:12]) * 32'd4096;
      if (i[6:0] == OP_LUI)   return upper;
      if (i[6:0] == OP_AUIPC) return pc + upper;
      return 32'd0;
   endfunction

   function automatic logic [4:0] exp_rd(input logic [31:0] i);
      if (i[6:0] == OP_BR || i[6:0] == OP_STORE) return 5'd0;
      return i[11:7];
   endfunction

   // Builds a branch word from a signed byte offset.
   function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs1, input logic [4:0] rs2);
      logic [12:0] b;
      b = 13'(imm);
      return {b[12], b[10:5], rs2, rs1, 3'b000, b[4:1], b[11], OP_BR};
   endfunction

   // Monitor: one comparison set per cycle, then the reference queue advances as the edge will.
   always @(negedge clk) begin
      if (!rst) begin
         check("rst_empty", 32'(empty), 32'd1);
         check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
         check("rst_load", 32'(load_instruction), 32'd0);
`ifdef IQ_PERF_EN
         m_full_cnt = 0;
         m_rob_cnt  = 0;
         check("rst_full_stall", full_stall_cnt, 32'd0);
         check("rst_rob_stall", rob_stall_cnt, 32'd0);
`endif
      end else begin
         m_load = (exp_q.size() > 0) && rob_free && rs_ready && !flush;
         check("empty", 32'(empty), 32'(exp_q.size() == 0));
         check("fetch_ready", 32'(fetch_ready), 32'(exp_q.size() < DEPTH));
         check("load_instruction", 32'(load_instruction), 32'(m_load));
         if (exp_q.size() > 0) begin
            m_h = exp_q[0];
            check("instruction_o", instruction_o, m_h.instr);
            check("inst_pc_o", inst_pc_o, m_h.pc);
            check("target_predict_o", target_predict_o, m_h.pred);
            check("pc_save_o", 32'(pc_save_o), 32'(m_h.tag));
            check("opcode_o", 32'(opcode_o), 32'(m_h.instr[6:0]));
            check("reg_num_o", 32'(reg_num_o), 32'(exp_rd(m_h.instr)));
            check("imm_data", imm_data, exp_imm(m_h.instr, m_h.pc));
            check("b_imm_o", b_imm_o, exp_bimm(m_h.instr));
            check("j_imm_o", j_imm_o, exp_jimm(m_h.instr));
         end
`ifdef IQ_PERF_EN
         check("full_stall_cnt", full_stall_cnt, m_full_cnt);
         check("rob_stall_cnt", rob_stall_cnt, m_rob_cnt);
         if (fetch_valid && exp_q.size() == DEPTH && m_full_cnt != 32'hFFFF_FFFF)
            m_full_cnt = m_full_cnt + 1;
         if (exp_q.size() > 0 && !(rob_free && rs_ready) && m_rob_cnt != 32'hFFFF_FFFF)
            m_rob_cnt = m_rob_cnt + 1;
`endif
         if (flush) exp_q.delete();
         else if (m_load) m_h = exp_q.pop_front();
      end
   end

   // Driver: one call per cycle; an accepted push joins the reference queue at the edge that writes it.
   task automatic cycle(input bit fv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] pr, input logic [2:0] tg,
                        input bit rf, input bit rr, input bit fl);
      @(posedge clk);
      #1;
      if (pend) exp_q.push_back(pend_item);
      pend          = 0;
      fetch_valid   = fv;
      fetch_instr   = ins;
      fetch_pc      = pc;
      fetch_predict = pr;
      fetch_pc_save = tg;
      rob_free      = rf;
      rs_ready      = rr;
      flush         = fl;
      if (fv && exp_q.size() < DEPTH && !fl) begin
         pend      = 1;
         pend_item = '{instr: ins, pc: pc, pred: pr, tag: tg};
      end
   endtask

   task automatic rand_push(input bit rf, input bit rr);
      logic [6:0]  ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
      logic [31:0] ins;
      ins      = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      cycle(1, ins, $urandom, $urandom, 3'($urandom_range(0, 7)), rf, rr, 0);
   endtask

   task automatic idle(input bit rf, input bit rr);
      cycle(0, 32'h0, 32'h0, 32'h0, 3'd0, rf, rr, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst         = 0;
      fetch_valid = 0;
      flush       = 0;
      pend        = 0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1;
   endtask

   logic [31:0] snap_full;
   logic [31:0] snap_rob;
   int          bias;

   initial begin
      rst = 0; flush = 0; fetch_valid = 0; fetch_instr = 0; fetch_pc = 0;
      fetch_predict = 0; fetch_pc_save = 0; rob_free = 0; rs_ready = 0;
      snap_full = 0; snap_rob = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1;

      // lui x5,0x12345 at pc 0x100: dispatchable exactly one cycle after the push
      cycle(1, {20'h12345, 5'd5, OP_LUI}, 32'h100, 32'h104, 3'd2, 1, 1, 0);
      @(negedge clk);
      check("t1_no_same_cycle_load", 32'(load_instruction), 32'd0);
      idle(1, 1);
      @(negedge clk);
      check("t1_load", 32'(load_instruction), 32'd1);
      check("t1_rd", 32'(reg_num_o), 32'd5);
      check("t1_imm", imm_data, 32'h1234_5000);
      idle(1, 1);

      // Fill while the ROB is stalled; the ninth offer must be refused
      repeat (9) rand_push(0, 1);
      @(negedge clk);
      check("t2_full_ready", 32'(fetch_ready), 32'd0);
      repeat (9) idle(1, 1);
      @(negedge clk);
      check("t2_drained", 32'(empty), 32'd1);

      // Full queue then concurrent push/pop across several pointer wraps
      repeat (8) rand_push(0, 0);
      repeat (20) rand_push(1, 1);
      repeat (9) idle(1, 1);

      // Flush with a concurrent offer: everything, including the offer, is dropped
      repeat (4) rand_push(0, 1);
      cycle(1, {20'hABCDE, 5'd7, OP_LUI}, 32'h300, 32'h0, 3'd1, 1, 1, 1);
      idle(1, 1);
      @(negedge clk);
      check("t4_flush_empty", 32'(empty), 32'd1);
      idle(1, 1);

      // Branch immediate -8 and auipc at 0x200
      cycle(1, enc_b(-8, 5'd1, 5'd2), 32'h180, 32'h179, 3'd3, 0, 1, 0);
      cycle(1, {20'h00001, 5'd3, OP_AUIPC}, 32'h200, 32'h204, 3'd4, 0, 1, 0);
      idle(0, 1);
      @(negedge clk);
      check("t5_b_imm", b_imm_o, 32'hFFFF_FFF8);
      check("t5_br_rd", 32'(reg_num_o), 32'd0);
      idle(1, 1);
      idle(0, 1);
      @(negedge clk);
      check("t5_auipc_imm", imm_data, 32'h0000_1200);
      idle(1, 1);
      idle(1, 1);

      // Reset mid-stream, then a fresh entry must flow normally
      repeat (3) rand_push(0, 1);
      do_reset();
      rand_push(1, 1);
      repeat (2) idle(1, 1);

`ifdef IQ_PERF_EN
      repeat (8) rand_push(0, 1);
      rand_push(0, 1);
      @(negedge clk);
      snap_full = full_stall_cnt;
      snap_rob  = rob_stall_cnt;
      repeat (5) rand_push(0, 1);
      @(negedge clk);
      check("t6_full_delta", full_stall_cnt - snap_full, 32'd5);
      check("t6_rob_delta", rob_stall_cnt - snap_rob, 32'd5);
      flush_and_check();
      do_reset();
      @(negedge clk);
      check("t6_full_after_rst", full_stall_cnt, 32'd0);
      check("t6_rob_after_rst", rob_stall_cnt, 32'd0);
`endif

      // Randomized traffic with varying backpressure and occasional flushes
      for (int blk = 0; blk < 8; blk++) begin
         bias = $urandom_range(1, 4);
         for (int c = 0; c < 100; c++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0] = (c % 3 == 0) ? OP_LUI : (c % 3 == 1) ? OP_AUIPC : 7'($urandom);
            cycle($urandom_range(0, 3) != 0, ins, $urandom, $urandom, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 4) < bias, $urandom_range(0, 4) < bias + 1,
                  $urandom_range(0, 39) == 0);
         end
      end
      repeat (10) idle(1, 1);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

`ifdef IQ_PERF_EN
   // Flush must leave the counters untouched.
   task automatic flush_and_check();
      cycle(0, 32'h0, 32'h0, 32'h0, 3'd0, 0, 1, 1);
      idle(0, 1);
      @(negedge clk);
      check("t6_flush_keeps_cnt", 32'(full_stall_cnt >= snap_full + 32'd5), 32'd1);
   endtask
`endif

endmodule
